// File: rtl/addr_scramble_pkg.sv
// Shared definitions for the address scrambler / descrambler pair:
// default geometry, key field layout and FSM state encoding.
package addr_scramble_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_TAP_W  = 4;
  localparam int DEF_ROUNDS = 12;

  // Round counter is sized for the largest legal ROUNDS (31).
  localparam int CNT_W    = 5;
  localparam int NUM_TAPS = 4;

  // Key layout {k4,k3,k2,k1}: field n (0-based, k1 = field 0) at n*TAP_W.
  localparam int K1_LSB = 0;
  localparam int K2_LSB = DEF_TAP_W;
  localparam int K3_LSB = 2 * DEF_TAP_W;
  localparam int K4_LSB = 3 * DEF_TAP_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int key_field_lsb(input int idx, input int tap_w);
    return idx * tap_w;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational step of the keyed LFSR: XOR of four tapped bits is
// shifted in at bit 0. Taps outside the register contribute nothing.
module lfsr_step
  import addr_scramble_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TAP_W  = DEF_TAP_W
) (
  input  logic [ADDR_W-1:0] x,
  input  logic [TAP_W-1:0]  k1,
  input  logic [TAP_W-1:0]  k2,
  input  logic [TAP_W-1:0]  k3,
  input  logic [TAP_W-1:0]  k4,
  output logic [ADDR_W-1:0] x_next
);

  logic [NUM_TAPS-1:0][TAP_W-1:0] taps;
  logic [NUM_TAPS-1:0]            tap_bit;
  logic                           fb;

  assign taps = {k4, k3, k2, k1};

  // Each tap is decoded to a one-hot position mask; an out-of-range index
  // yields an all-zero mask, so that tap reads as 0.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      logic [ADDR_W-1:0] sel;
      for (gj = 0; gj < ADDR_W; gj++) begin : g_pos
        assign sel[gj] = (32'(taps[gi]) == gj);
      end
      assign tap_bit[gi] = ^(x & sel);
    end
  endgenerate

  // Duplicate taps cancel here by design.
  assign fb     = ^tap_bit;
  assign x_next = {x[ADDR_W-2:0], fb};

endmodule

// File: rtl/addr_scramble.sv
// Address scrambler: accepts an address/key pair, runs ROUNDS keyed LFSR
// steps and presents the result on a valid/ready output.
module addr_scramble
  import addr_scramble_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TAP_W  = DEF_TAP_W,
  parameter int ROUNDS = DEF_ROUNDS   // legal range 1..31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [NUM_TAPS*TAP_W-1:0]  key,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic                       busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  state_e                         state_reg, state_next;
  logic [ADDR_W-1:0]              shift_reg, shift_next;
  logic [ADDR_W-1:0]              step_x;
  logic [CNT_W-1:0]               cnt_reg, cnt_next;
  logic [NUM_TAPS-1:0][TAP_W-1:0] taps_reg, taps_next;
  logic [NUM_TAPS-1:0][TAP_W-1:0] key_taps;
  logic                           out_valid_reg, out_valid_next;
  logic [ADDR_W-1:0]              out_addr_reg, out_addr_next;
  logic                           ready_int;
  logic                           accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_key
      assign key_taps[gi] = key[key_field_lsb(gi, TAP_W) +: TAP_W];
    end
  endgenerate

  lfsr_step #(
    .ADDR_W (ADDR_W),
    .TAP_W  (TAP_W)
  ) u_step (
    .x      (shift_reg),
    .k1     (taps_reg[0]),
    .k2     (taps_reg[1]),
    .k3     (taps_reg[2]),
    .k4     (taps_reg[3]),
    .x_next (step_x)
  );

  // A consumed result frees the slot in the same cycle, enabling back-to-back issue.
  assign ready_int = (state_reg == ST_IDLE) ||
                     ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && ready_int;

  // Handshake outputs are forced low while reset is asserted.
  assign in_ready  = reset && ready_int;
  assign busy      = reset && (state_reg == ST_RUN);
  assign out_valid = reset && out_valid_reg;
  assign out_addr  = out_addr_reg;

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    cnt_next       = cnt_reg;
    taps_next      = taps_reg;
    out_valid_next = out_valid_reg;
    out_addr_next  = out_addr_reg;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_RUN: begin
        shift_next = step_x;
        if (cnt_reg == LAST_CNT) begin
          state_next     = ST_DONE;
          cnt_next       = '0;
          out_valid_next = 1'b1;
          out_addr_next  = step_x;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next     = ST_IDLE;
          out_valid_next = 1'b0;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        out_valid_next = 1'b0;
      end
    endcase

    // Accept overrides the consume path so DONE can go straight back to RUN.
    if (accept) begin
      state_next = ST_RUN;
      shift_next = in_addr;
      taps_next  = key_taps;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      taps_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      taps_reg      <= taps_next;
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
    end
  end

endmodule
